// File: rtl/cpu_pkg.sv
// Shared CPU constants for register-file related blocks.
//   REG_W    : register index width
//   NUM_REGS : architectural register count
//   REG_ZERO : hardwired-zero register index (never tracked)
package cpu_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of destination register tags.
// Ports:
//   clk, rst     : clock, async active-high reset
//   flush        : synchronous clear of pointers and occupancy (wins over push/pop)
//   push, push_tag : enqueue a tag at the tail
//   pop          : dequeue the head
//   head_tag     : tag at the head (valid when !empty)
//   occupancy    : explicit entry count, 0..DEPTH
//   full, empty  : occupancy == DEPTH / occupancy == 0
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module tag_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [REG_W-1:0] push_tag,
  input  logic             pop,
  output logic [REG_W-1:0] head_tag,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_tag = mem[rd_ptr];
  assign full     = (occupancy == CNT_W'(DEPTH));
  assign empty    = (occupancy == '0);

  // Storage has no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order RAW-hazard scoreboard for the 32x32 register file.
// Ports:
//   clk, rst            : clock, async active-high reset
//   issue_*             : instruction presented by decode (sources, dest)
//   issue_stall         : combinational; instruction not accepted this cycle
//   wb_valid, wb_reg    : write-back this cycle (same strobe as RF write enable)
//   flush               : synchronous discard of all in-flight writes
//   busy_mask           : registered per-register pending-write flags
//   occupancy           : registered in-flight entry count
//   order_err           : sticky; write-back out of order or with nothing in flight
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_rs,
  input  logic [REG_W-1:0]    issue_rt,
  input  logic                issue_use_rs,
  input  logic                issue_use_rt,
  input  logic                issue_wr_en,
  input  logic [REG_W-1:0]    issue_rd,
  output logic                issue_stall,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    occupancy,
  output logic                order_err
);

  logic [CNT_W-1:0]    pend      [NUM_REGS];
  logic [CNT_W-1:0]    pend_next [NUM_REGS];
  logic [NUM_REGS-1:0] busy_next;

  logic [REG_W-1:0] head_tag;
  logic             fifo_full;
  logic             fifo_empty;

  logic wb_req;
  logic pop;
  logic err_set;
  logic rs_busy;
  logic rt_busy;
  logic full_block;
  logic accept;
  logic push;

  assign wb_req  = wb_valid && (wb_reg != REG_ZERO);
  assign pop     = wb_req && !fifo_empty;
  assign err_set = wb_req && (fifo_empty || (wb_reg != head_tag));

  // A register written back this cycle is still busy: the RF read samples
  // the array before the same-edge write lands.
  assign rs_busy = (issue_rs != REG_ZERO) &&
                   ((pend[issue_rs] != '0) || (wb_valid && (wb_reg == issue_rs)));
  assign rt_busy = (issue_rt != REG_ZERO) &&
                   ((pend[issue_rt] != '0) || (wb_valid && (wb_reg == issue_rt)));

  assign full_block = issue_wr_en && (issue_rd != REG_ZERO) && fifo_full && !wb_valid;

  assign issue_stall = issue_valid &&
                       ((issue_use_rs && rs_busy) || (issue_use_rt && rt_busy) || full_block);

  assign accept = issue_valid && !issue_stall;

  // The stall equation lets a full FIFO accept whenever wb_valid is high, even
  // for an ignored write-back to r0; the extra guard keeps the FIFO from
  // overflowing in that corner.
  assign push = accept && issue_wr_en && (issue_rd != REG_ZERO) && (!fifo_full || pop);

  tag_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_tag  (issue_rd),
    .pop       (pop),
    .head_tag  (head_tag),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pop always decrements the head's counter; on a match that is wb_reg,
  // on a mismatch it keeps counters consistent with the FIFO contents.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_next[r] = pend[r];
      if (push && (issue_rd == REG_W'(r))) begin
        pend_next[r] = pend_next[r] + CNT_W'(1);
      end
      if (pop && (head_tag == REG_W'(r))) begin
        pend_next[r] = pend_next[r] - CNT_W'(1);
      end
      busy_next[r] = (pend_next[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend[r] <= '0;
      end
      busy_mask <= '0;
      order_err <= 1'b0;
    end else begin
      if (err_set) begin
        order_err <= 1'b1;
      end
      if (flush) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          pend[r] <= '0;
        end
        busy_mask <= '0;
      end else begin
        for (int r = 0; r < NUM_REGS; r++) begin
          pend[r] <= pend_next[r];
        end
        busy_mask <= busy_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_use_rs;
  logic        issue_use_rt;
  logic        issue_wr_en;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        flush;
  logic [31:0] busy_mask;
  logic [CNT_W-1:0] occupancy;
  logic        order_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_wr_en  (issue_wr_en),
    .issue_rd     (issue_rd),
    .issue_stall  (issue_stall),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .flush        (flush),
    .busy_mask    (busy_mask),
    .occupancy    (occupancy),
    .order_err    (order_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_rs     = 5'd0;
    issue_rt     = 5'd0;
    issue_use_rs = 1'b0;
    issue_use_rt = 1'b0;
    issue_wr_en  = 1'b0;
    issue_rd     = 5'd0;
    wb_valid     = 1'b0;
    wb_reg       = 5'd0;
    flush        = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; sampling happens #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_wr_en = 1'b1;
    issue_rd    = rd;
  endtask

  task automatic do_wb(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_reg   = r;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    check("rst_busy", busy_mask, 32'h0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_err", 32'(order_err), 32'd0);
    issue_wr(5'd5);
    #1;
    check("rst_stall", 32'(issue_stall), 32'd0);
    idle();
    step();
    rst = 1'b0;
    step();

    // Basic push: rs=3 rt=4 rd=5
    issue_valid = 1'b1; issue_rs = 5'd3; issue_rt = 5'd4;
    issue_use_rs = 1'b1; issue_use_rt = 1'b1; issue_wr_en = 1'b1; issue_rd = 5'd5;
    #1;
    check("push5_stall", 32'(issue_stall), 32'd0);
    step();
    idle();
    #1;
    check("push5_busy", busy_mask, 32'h20);
    check("push5_occ", 32'(occupancy), 32'd1);

    // RAW on r5
    issue_valid = 1'b1; issue_rs = 5'd5; issue_use_rs = 1'b1;
    #1;
    check("raw_stall0", 32'(issue_stall), 32'd1);
    step();
    check("raw_stall1", 32'(issue_stall), 32'd1);
    do_wb(5'd5);
    #1;
    check("raw_wb_stall", 32'(issue_stall), 32'd1);
    step();
    wb_valid = 1'b0; wb_reg = 5'd0;
    #1;
    check("raw_after_stall", 32'(issue_stall), 32'd0);
    check("raw_after_busy", busy_mask, 32'h0);
    check("raw_after_occ", 32'(occupancy), 32'd0);
    idle();

    // Fill the FIFO with 1..4
    for (int i = 1; i <= 4; i++) begin
      issue_wr(5'(i));
      step();
    end
    idle();
    #1;
    check("full_occ", 32'(occupancy), 32'd4);
    check("full_busy", busy_mask, 32'h1E);
    issue_wr(5'd6);
    #1;
    check("full_stall", 32'(issue_stall), 32'd1);
    do_wb(5'd1);
    #1;
    check("full_wb_stall", 32'(issue_stall), 32'd0);
    step();
    idle();
    #1;
    check("full_pp_occ", 32'(occupancy), 32'd4);
    check("full_pp_busy", busy_mask, 32'h5C);
    do_wb(5'd2); step();
    do_wb(5'd3); step();
    do_wb(5'd4); step();
    do_wb(5'd6); step();
    idle();
    #1;
    check("drain_occ", 32'(occupancy), 32'd0);
    check("drain_busy", busy_mask, 32'h0);
    check("drain_err", 32'(order_err), 32'd0);

    // Duplicate destination r7
    issue_wr(5'd7); step();
    issue_wr(5'd7); step();
    idle();
    #1;
    check("dup_busy", busy_mask, 32'h80);
    check("dup_occ", 32'(occupancy), 32'd2);
    do_wb(5'd7); step();
    idle();
    #1;
    check("dup_wb1_busy", busy_mask, 32'h80);
    check("dup_wb1_occ", 32'(occupancy), 32'd1);
    do_wb(5'd7); step();
    idle();
    #1;
    check("dup_wb2_busy", busy_mask, 32'h0);

    // Zero register handling
    issue_wr(5'd0); issue_rs = 5'd0; issue_use_rs = 1'b1;
    #1;
    check("zero_stall", 32'(issue_stall), 32'd0);
    step();
    idle();
    #1;
    check("zero_occ", 32'(occupancy), 32'd0);
    do_wb(5'd0); step();
    idle();
    #1;
    check("zero_wb_err", 32'(order_err), 32'd0);
    check("zero_wb_occ", 32'(occupancy), 32'd0);

    // Same-cycle push and pop of r12
    issue_wr(5'd12); step();
    issue_wr(5'd12); do_wb(5'd12);
    #1;
    check("pp12_stall", 32'(issue_stall), 32'd0);
    step();
    idle();
    #1;
    check("pp12_busy", busy_mask, 32'h1000);
    check("pp12_occ", 32'(occupancy), 32'd1);
    do_wb(5'd12); step();
    idle();
    #1;
    check("pp12_clear", busy_mask, 32'h0);

    // Order error: push 8, write back 9
    issue_wr(5'd8); step();
    idle();
    do_wb(5'd9); step();
    idle();
    #1;
    check("ord_err", 32'(order_err), 32'd1);
    check("ord_occ", 32'(occupancy), 32'd0);
    check("ord_busy", busy_mask, 32'h0);

    // Flush with a concurrent issue
    issue_wr(5'd10); step();
    issue_wr(5'd11); step();
    idle();
    #1;
    check("pre_flush_busy", busy_mask, 32'hC00);
    issue_wr(5'd13); flush = 1'b1; step();
    idle();
    #1;
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_busy", busy_mask, 32'h0);
    check("flush_err", 32'(order_err), 32'd1);

    // Async reset mid-cycle
    issue_wr(5'd14); step();
    idle();
    #1;
    check("pre_rst_busy", busy_mask, 32'h4000);
    rst = 1'b1;
    #1;
    check("arst_busy", busy_mask, 32'h0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_err", 32'(order_err), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Write-back with nothing in flight
    do_wb(5'd15); step();
    idle();
    #1;
    check("empty_wb_err", 32'(order_err), 32'd1);
    check("empty_wb_occ", 32'(occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- In-order RAW-hazard scoreboard for the 32x32 register file. It sits between decode/issue and the register file read ports.
- Each issued instruction that writes a register has its destination recorded in an in-flight FIFO. Issue is stalled while any source register has a pending write.
- Writebacks retire FIFO entries in order.
- The register file's reads are registered and sample the array before the same-edge write lands, so a register being written back in the current cycle still counts as busy.

Parameters:
- DEPTH, 4, maximum in-flight writing instructions (power of 2, >=2)
- CNT_W, $clog2(DEPTH+1), width of per-register pending counters and occupancy

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_rs  in  5  first source register
- issue_rt  in  5  second source register
- issue_use_rs  in  1  instruction reads rs
- issue_use_rt  in  1  instruction reads rt
- issue_wr_en  in  1  instruction writes a register
- issue_rd  in  5  destination register
- issue_stall  out  1  combinational; instruction is not accepted this cycle
- wb_valid  in  1  write-back occurring this cycle (same signal drives RF write_back_en)
- wb_reg  in  5  write-back destination
- flush  in  1  synchronous; discard all pending entries
- busy_mask  out  32  registered; bit r = 1 when reg r has a pending write
- occupancy  out  CNT_W  registered FIFO entry count
- order_err  out  1  sticky; write-back did not match FIFO head or arrived with FIFO empty

Behaviour:
- Reset (async, rst=1): FIFO pointers=0, occupancy=0, all pending counters=0, busy_mask=0, order_err=0. issue_stall then depends only on FIFO full (false).
- Register 0 is never tracked. A destination of 0 is not pushed. A source of 0 never stalls.
- src_busy(r) = r!=0 && (pend[r]!=0 || (wb_valid && wb_reg==r)).
- issue_stall = issue_valid && ((issue_use_rs && src_busy(issue_rs)) || (issue_use_rt && src_busy(issue_rt)) || (issue_wr_en && issue_rd!=0 && occupancy==DEPTH && !(wb_valid))).
- A full FIFO accepts a push in the same cycle as a pop.
- The issue stall is combinational from all inputs; it has no registered path.
- Accept = issue_valid && !issue_stall.
- Push on accept: when issue_wr_en && issue_rd!=0, write issue_rd at the tail, advance the tail, and increment pend[issue_rd].
- Pop on wb_valid with wb_reg!=0 and occupancy>0: compare wb_reg to the head.
  - Match: advance the head and decrement pend[wb_reg].
  - Mismatch: set order_err, still pop, and decrement pend[head] (not pend[wb_reg]) so the counters remain consistent.
- wb_valid with wb_reg==0 is ignored.
- wb_valid with occupancy==0 sets order_err with no pop.
- Simultaneous push and pop of the same register: the increment and decrement net to zero change. occupancy is unchanged.
- Pointers wrap modulo DEPTH. occupancy is an explicit counter, not derived from pointer difference.
- pend[r] saturation is impossible because pend[r] <= occupancy <= DEPTH. CNT_W is sized for DEPTH.
- busy_mask[r] is the registered value of (pend_next[r]!=0).
- flush (synchronous, priority over push/pop in the same cycle): pointers, occupancy and counters go to 0, busy_mask goes to 0. order_err is not cleared. An issue accepted in the flush cycle is discarded.
- rst asserted mid-operation clears all state immediately, independent of clk.

Decomposition:
- Shared package (cpu_pkg): REG_W=5, NUM_REGS=32, REG_ZERO=5'd0.
- One sub-module, tag_fifo: DEPTH-entry, 5-bit-wide, synchronous-push/pop FIFO with head output, occupancy, flush, and async reset.
- Counters, the hazard compare and the stall logic stay in reg_scoreboard.

Test Plan:
- Reset then idle: issue rs=3, rt=4, use both, wr rd=5 -> stall=0, next cycle busy_mask=0x20, occupancy=1.
- RAW: after the above, issue rs=5 -> stall=1 until wb_valid wb_reg=5. In the wb cycle stall is still 1; the next cycle stall=0 and busy_mask=0.
- Full: push rd=1,2,3,4 (DEPTH=4), then issue wr rd=6 with no wb -> stall=1. Same request with wb_valid wb_reg=1 -> accepted, occupancy stays 4, busy_mask=0x5C.
- Duplicate dest: push rd=7 twice -> pend[7]=2. One wb of 7 leaves busy_mask[7]=1; the second clears it.
- Zero reg: issue wr rd=0 with rs=0 -> no stall, occupancy unchanged. wb_reg=0 -> no pop, order_err=0.
- Order/flush: push rd=8, wb_reg=9 -> order_err=1, occupancy=0, busy_mask[8]=0. Then push 10,11 and flush -> occupancy=0, busy_mask=0, order_err stays 1. Assert rst mid-sequence -> all outputs 0 before the next clk edge.
